cajero_control: RTL and testbench

- Transaction controller for the automatic cashier.
- Sequences one card session: card accepted, 4-digit PIN entry and check, one deposit or withdrawal against a 64-bit balance.
- Drives the status/strobe outputs consumed by the cashier bench (balance_actualizado, entregar_dinero, pin_incorrecto, advertencia, bloqueo, fondos_insuficientes).
- Holds the attempt counter that enforces card blocking.

---
 rtl/cajero_if.sv | 59 +++++
 rtl/cajero_control.sv | 183 ++++++++++++++++++
 tb/tb_cajero_control.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cajero_if.sv
// Signal bundle between the cashier bench (master) and the
// transaction controller (slave).
interface cajero_if #(
    parameter int ANCHO_BALANCE = 64,
    parameter int ANCHO_MONTO   = 32
);
    logic                     tarjeta_recibida;
    logic                     tipo_trans;
    logic                     digito_stb;
    logic [3:0]               digito;
    logic [15:0]              pin;
    logic [ANCHO_BALANCE-1:0] balance_inicial;
    logic [ANCHO_MONTO-1:0]   monto;
    logic                     monto_stb;

    logic [ANCHO_BALANCE-1:0] balance;
    logic                     balance_actualizado;
    logic                     entregar_dinero;
    logic                     pin_incorrecto;
    logic                     advertencia;
    logic                     bloqueo;
    logic                     fondos_insuficientes;

    modport master (
        output tarjeta_recibida,
        output tipo_trans,
        output digito_stb,
        output digito,
        output pin,
        output balance_inicial,
        output monto,
        output monto_stb,
        input  balance,
        input  balance_actualizado,
        input  entregar_dinero,
        input  pin_incorrecto,
        input  advertencia,
        input  bloqueo,
        input  fondos_insuficientes
    );

    modport slave (
        input  tarjeta_recibida,
        input  tipo_trans,
        input  digito_stb,
        input  digito,
        input  pin,
        input  balance_inicial,
        input  monto,
        input  monto_stb,
        output balance,
        output balance_actualizado,
        output entregar_dinero,
        output pin_incorrecto,
        output advertencia,
        output bloqueo,
        output fondos_insuficientes
    );
endinterface

// File: rtl/cajero_control.sv
// Card-session controller: PIN entry and check, attempt counting,
// and a single deposit or withdrawal against the working balance.
module cajero_control #(
    parameter int MAX_INTENTOS  = 3,
    parameter int ANCHO_BALANCE = 64,
    parameter int ANCHO_MONTO   = 32
) (
    input logic     clock,
    input logic     reset,
    cajero_if.slave bus
);

    localparam int IW = $clog2(MAX_INTENTOS + 1);

    typedef enum logic [2:0] {
        ESPERA_TARJETA,
        PIN_ENTRADA,
        VERIFICAR_PIN,
        ESPERA_MONTO,
        TRANSACCION,
        BLOQUEO
    } estado_t;

    estado_t                  state_q, state_d;
    logic [15:0]              digitos_q, digitos_d;
    logic [2:0]               cuenta_q, cuenta_d;
    logic [IW-1:0]            intentos_q, intentos_d;
    logic [ANCHO_BALANCE-1:0] balance_q, balance_d;
    logic [ANCHO_BALANCE-1:0] monto_q, monto_d;
    logic                     tipo_q, tipo_d;
    logic                     act_q, act_d;
    logic                     ent_q, ent_d;
    logic                     pinc_q, pinc_d;
    logic                     adv_q, adv_d;
    logic                     bloq_q, bloq_d;
    logic                     fondos_q, fondos_d;

    logic [IW-1:0]            intentos_nuevo;
    logic [ANCHO_BALANCE:0]   suma;

    assign intentos_nuevo = intentos_q + IW'(1);
    assign suma = {1'b0, balance_q} + {1'b0, monto_q};

    always_comb begin
        state_d    = state_q;
        digitos_d  = digitos_q;
        cuenta_d   = cuenta_q;
        intentos_d = intentos_q;
        balance_d  = balance_q;
        monto_d    = monto_q;
        tipo_d     = tipo_q;
        adv_d      = adv_q;
        bloq_d     = bloq_q;
        act_d      = 1'b0;
        ent_d      = 1'b0;
        pinc_d     = 1'b0;
        fondos_d   = 1'b0;

        unique case (state_q)
            ESPERA_TARJETA: begin
                if (bus.tarjeta_recibida) begin
                    balance_d = bus.balance_inicial;
                    digitos_d = '0;
                    cuenta_d  = '0;
                    state_d   = PIN_ENTRADA;
                end
            end

            PIN_ENTRADA: begin
                // card removal wins over a coincident digit
                if (!bus.tarjeta_recibida) begin
                    state_d = ESPERA_TARJETA;
                end else if (bus.digito_stb) begin
                    digitos_d = {digitos_q[11:0], bus.digito};
                    cuenta_d  = cuenta_q + 3'd1;
                    if (cuenta_q == 3'd3) begin
                        state_d = VERIFICAR_PIN;
                    end
                end
            end

            VERIFICAR_PIN: begin
                if (!bus.tarjeta_recibida) begin
                    state_d = ESPERA_TARJETA;
                end else if (digitos_q == bus.pin) begin
                    intentos_d = '0;
                    adv_d      = 1'b0;
                    state_d    = ESPERA_MONTO;
                end else begin
                    intentos_d = intentos_nuevo;
                    pinc_d     = 1'b1;
                    cuenta_d   = '0;
                    digitos_d  = '0;
                    if (intentos_nuevo >= IW'(MAX_INTENTOS)) begin
                        bloq_d  = 1'b1;
                        adv_d   = 1'b1;
                        state_d = BLOQUEO;
                    end else begin
                        if (intentos_nuevo == IW'(MAX_INTENTOS - 1)) begin
                            adv_d = 1'b1;
                        end
                        state_d = PIN_ENTRADA;
                    end
                end
            end

            ESPERA_MONTO: begin
                if (!bus.tarjeta_recibida) begin
                    state_d = ESPERA_TARJETA;
                end else if (bus.monto_stb) begin
                    monto_d = ANCHO_BALANCE'(bus.monto);
                    tipo_d  = bus.tipo_trans;
                    state_d = TRANSACCION;
                end
            end

            TRANSACCION: begin
                state_d = ESPERA_TARJETA;
                if (!tipo_q) begin
                    // deposit saturates instead of wrapping
                    balance_d = suma[ANCHO_BALANCE] ? '1
                              : suma[ANCHO_BALANCE-1:0];
                    act_d     = 1'b1;
                end else if (monto_q <= balance_q) begin
                    balance_d = balance_q - monto_q;
                    act_d     = 1'b1;
                    ent_d     = 1'b1;
                end else begin
                    fondos_d  = 1'b1;
                end
            end

            BLOQUEO: begin
                bloq_d = 1'b1;
            end

            default: begin
                state_d = ESPERA_TARJETA;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ESPERA_TARJETA;
            digitos_q  <= '0;
            cuenta_q   <= '0;
            intentos_q <= '0;
            balance_q  <= '0;
            monto_q    <= '0;
            tipo_q     <= 1'b0;
            act_q      <= 1'b0;
            ent_q      <= 1'b0;
            pinc_q     <= 1'b0;
            adv_q      <= 1'b0;
            bloq_q     <= 1'b0;
            fondos_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            digitos_q  <= digitos_d;
            cuenta_q   <= cuenta_d;
            intentos_q <= intentos_d;
            balance_q  <= balance_d;
            monto_q    <= monto_d;
            tipo_q     <= tipo_d;
            act_q      <= act_d;
            ent_q      <= ent_d;
            pinc_q     <= pinc_d;
            adv_q      <= adv_d;
            bloq_q     <= bloq_d;
            fondos_q   <= fondos_d;
        end
    end

    assign bus.balance              = balance_q;
    assign bus.balance_actualizado  = act_q;
    assign bus.entregar_dinero      = ent_q;
    assign bus.pin_incorrecto       = pinc_q;
    assign bus.advertencia          = adv_q;
    assign bus.bloqueo              = bloq_q;
    assign bus.fondos_insuficientes = fondos_q;

endmodule

// File: tb/tb_cajero_control.sv
// Directed scoreboard bench for the cashier controller: stimulus queues
// expected output snapshots, a negedge monitor pops them on every pulse.
module tb_cajero_control;

    logic clock;
    logic reset;
    logic probe;
    logic done_chk;
    logic fin;
    int   checks;
    int   errors;

    typedef struct {
        string       name;
        logic [5:0]  flags;
        logic [63:0] bal;
    } exp_t;

    exp_t exp_q[$];

    cajero_if bus ();

    cajero_control dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // flags: {act, entregar, pin_inc, fondos, adv, bloq}
    logic [5:0] got_f;
    assign got_f = {bus.balance_actualizado, bus.entregar_dinero,
                    bus.pin_incorrecto, bus.fondos_insuficientes,
                    bus.advertencia, bus.bloqueo};

    always @(negedge clock) begin
        exp_t e;
        if (!reset && (bus.balance_actualizado || bus.entregar_dinero ||
                       bus.pin_incorrecto || bus.fondos_insuficientes ||
                       probe)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected got flags=%b bal=%0h",
                         got_f, bus.balance);
            end else begin
                e = exp_q.pop_front();
                if (got_f !== e.flags || bus.balance !== e.bal) begin
                    errors++;
                    $display("FAIL %s got flags=%b bal=%0h need flags=%b bal=%0h",
                             e.name, got_f, bus.balance, e.flags, e.bal);
                end
            end
        end
        if (done_chk && !fin) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL leftover got %0d pending need 0",
                         exp_q.size());
            end
            fin = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input string n, input logic [5:0] f,
                        input logic [63:0] b);
        exp_t e;
        e.name  = n;
        e.flags = f;
        e.bal   = b;
        exp_q.push_back(e);
    endtask

    task automatic do_probe(input string n, input logic [5:0] f,
                            input logic [63:0] b);
        push(n, f, b);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic digit(input logic [3:0] d);
        bus.digito     = d;
        bus.digito_stb = 1'b1;
        tick();
        bus.digito_stb = 1'b0;
    endtask

    task automatic pin4(input logic [15:0] p);
        for (int i = 0; i < 4; i++) begin
            digit(p[15 - 4*i -: 4]);
        end
    endtask

    task automatic start(input logic [63:0] bi);
        bus.balance_inicial  = bi;
        bus.tarjeta_recibida = 1'b1;
        tick();
    endtask

    task automatic transact(input logic [31:0] m, input logic t);
        bus.monto      = m;
        bus.tipo_trans = t;
        bus.monto_stb  = 1'b1;
        tick();
        bus.monto_stb  = 1'b0;
        tick();
    endtask

    task automatic leave();
        bus.tarjeta_recibida = 1'b0;
        tick();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        probe    = 1'b0;
        done_chk = 1'b0;
        fin      = 1'b0;
        reset    = 1'b1;
        bus.tarjeta_recibida = 1'b0;
        bus.tipo_trans       = 1'b0;
        bus.digito_stb       = 1'b0;
        bus.digito           = 4'h0;
        bus.pin              = 16'h1234;
        bus.balance_inicial  = 64'd0;
        bus.monto            = 32'd0;
        bus.monto_stb        = 1'b0;

        do_reset();
        do_probe("reset", 6'b000000, 64'd0);

        // withdrawal within funds
        start(64'd1000);
        pin4(16'h1234);
        tick();
        push("retiro", 6'b110000, 64'd700);
        transact(32'd300, 1'b1);
        leave();

        // withdrawal beyond funds
        start(64'd1000);
        pin4(16'h1234);
        tick();
        push("fondos", 6'b000100, 64'd1000);
        transact(32'd1500, 1'b1);
        leave();

        // plain deposit
        start(64'd1000);
        pin4(16'h1234);
        tick();
        push("deposito", 6'b100000, 64'd1234);
        transact(32'd234, 1'b0);
        leave();

        // saturating deposit
        start(64'hFFFF_FFFF_FFFF_FFF0);
        pin4(16'h1234);
        tick();
        push("saturar", 6'b100000, 64'hFFFF_FFFF_FFFF_FFFF);
        transact(32'hFFFF_FFFF, 1'b0);
        leave();

        // three wrong PINs block the card
        do_reset();
        start(64'd500);
        push("mal1", 6'b001000, 64'd500);
        pin4(16'h1111);
        tick();
        push("mal2", 6'b001010, 64'd500);
        pin4(16'h1111);
        tick();
        push("mal3", 6'b001011, 64'd500);
        pin4(16'h1111);
        tick();
        pin4(16'h1234);
        transact(32'd10, 1'b0);
        do_probe("bloq_hold", 6'b000011, 64'd500);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_probe("bloq_reset", 6'b000000, 64'd0);
        leave();

        // correct PIN clears the warning
        do_reset();
        start(64'd2000);
        push("w1", 6'b001000, 64'd2000);
        pin4(16'h1111);
        tick();
        push("w2", 6'b001010, 64'd2000);
        pin4(16'h2222);
        tick();
        pin4(16'h1234);
        tick();
        do_probe("adv_clr", 6'b000000, 64'd2000);
        push("dep1", 6'b100000, 64'd2001);
        transact(32'd1, 1'b0);
        leave();
        start(64'd2000);
        push("fresh", 6'b001000, 64'd2000);
        pin4(16'h9999);
        tick();
        leave();

        // removal coincident with a digit strobe
        do_reset();
        start(64'd777);
        digit(4'h1);
        digit(4'h2);
        bus.tarjeta_recibida = 1'b0;
        digit(4'h3);
        do_probe("quitar", 6'b000000, 64'd777);
        start(64'd777);
        pin4(16'h1234);
        tick();
        push("reinsert", 6'b110000, 64'd700);
        transact(32'd77, 1'b1);
        leave();

        // removal during the compare cycle
        start(64'd50);
        pin4(16'h1111);
        leave();
        do_probe("quitar_ver", 6'b000000, 64'd50);

        // removal coincident with the amount strobe
        start(64'd50);
        pin4(16'h1234);
        tick();
        bus.tarjeta_recibida = 1'b0;
        transact(32'd5, 1'b0);
        do_probe("quitar_monto", 6'b000000, 64'd50);

        done_chk = 1'b1;
        for (int i = 0; i < 10 && !fin; i++) begin
            tick();
        end
        if (!fin) begin
            $display("FAIL final_check got no response need done");
            $fatal(1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout need finish");
        $fatal(1);
    end

endmodule
